// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store unit sitting between the EX stage and a
//   small word-addressed data memory with a combinational read port.
//   Each accepted request is bounds-checked, performs one memory access and,
//   for loads, returns the read word to writeback one cycle later.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   req_valid/_is_store   EX request handshake (req_ready high only in IDLE)
//   req_addr/_wdata/_rd   effective address, store data, load destination
//   mem_read/_write       data-memory strobes (one cycle, never both)
//   mem_addr/_wdata       data-memory address and write data
//   mem_rdata             data-memory read data
//   wb_valid/_rd/_data    load result to writeback
//   store_done, addr_err  one-cycle status pulses
//   load_cnt, store_cnt   8-bit wrapping completed-op counters
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request
// ACCESS | drive one memory strobe for the captured op
// RESP   | present the captured load result on the writeback port
// ERR    | address out of range; pulse addr_err, touch nothing else
module load_store_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_rd,
  output logic              req_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              store_done,
  output logic              addr_err,
  output logic [7:0]        load_cnt,
  output logic [7:0]        store_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Only the in-range address bits are kept: the upper bits matter solely for
  // the accept-time range check, which already picked ACCESS or ERR.
  logic              r_is_store;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [2:0]        r_wb_rd;
  logic [7:0]        r_load_cnt;
  logic [7:0]        r_store_cnt;

  logic w_accept;
  logic w_addr_bad;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_addr_bad = (req_addr >> ADDR_W) != '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // All strobes decode from the state register and captured registers only,
  // so an asynchronous reset drops them immediately.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    store_done = 1'b0;
    addr_err   = 1'b0;
    wb_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_addr_bad ? S_ERR : S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (r_is_store) begin
          mem_write  = 1'b1;
          store_done = 1'b1;
          w_next     = S_IDLE;
        end else begin
          mem_read = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        wb_valid = 1'b1;
        w_next   = S_IDLE;
      end
      S_ERR: begin
        addr_err = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
    end else if (w_accept) begin
      r_is_store <= req_is_store;
      r_addr     <= req_addr[ADDR_W-1:0];
      r_wdata    <= req_wdata;
      r_rd       <= req_rd;
    end
  end

  // Writeback payload is only updated by a load access, so it holds the last
  // load result; wb_valid alone marks it fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_data <= '0;
      r_wb_rd   <= '0;
    end else if (r_state == S_ACCESS && !r_is_store) begin
      r_wb_data <= mem_rdata;
      r_wb_rd   <= r_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else begin
      if (r_state == S_RESP) begin
        r_load_cnt <= r_load_cnt + 8'd1;
      end
      if (r_state == S_ACCESS && r_is_store) begin
        r_store_cnt <= r_store_cnt + 8'd1;
      end
    end
  end

  assign wb_data   = r_wb_data;
  assign wb_rd     = r_wb_rd;
  assign load_cnt  = r_load_cnt;
  assign store_cnt = r_store_cnt;

endmodule
